// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: bus widths,
// register offsets, STATUS bit positions and FSM state encodings.
package uart_tx_mmio_pkg;

   localparam int BUS_AW = 32;
   localparam int BUS_DW = 32;

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DIVISOR = 2'd2;
   localparam logic [1:0] REG_RSVD    = 2'd3;

   localparam int STAT_BUSY  = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_EMPTY = 2;
   localparam int STAT_OVF   = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // A divisor of zero would never end a bit, so it is clamped to one clock.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Data-RAM style bus into the UART transmitter register block.
interface uart_tx_mmio_if;
   import uart_tx_mmio_pkg::*;

   logic              ce;
   logic              we;
   logic [BUS_AW-1:0] addr;
   logic [BUS_DW-1:0] data_i;
   logic [BUS_DW-1:0] data_o;

   modport master (output ce, output we, output addr, output data_i, input data_o);
   modport slave  (input ce, input we, input addr, input data_i, output data_o);

endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO feeding the UART transmitter; depth must be a power of two.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIVISOR registers,
// a TX FIFO and the bit-timing FSM driving a registered serial line.
module uart_tx_mmio
   import uart_tx_mmio_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int DEFAULT_DIV = 434
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_mmio_if.slave bus,
   output logic          tx,
   output logic          irq
);

   logic [1:0]  state;
   logic [15:0] cnt;
   logic [15:0] bit_time;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        tx_q;
   logic [15:0] divisor;
   logic        overflow;

   logic        wr_acc;
   logic        rd_acc;
   logic [1:0]  reg_sel;
   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  fifo_dout;
   logic        busy;
   logic        bit_end;
   logic [BUS_DW-1:0] rdata;
   logic        unused_bits;

   assign wr_acc  = bus.ce && bus.we;
   assign rd_acc  = bus.ce && !bus.we;
   assign reg_sel = bus.addr[3:2];
   assign unused_bits = ^{bus.addr[BUS_AW-1:4], bus.addr[1:0], bus.data_i[BUS_DW-1:16]};

   // full is the pre-edge value, so a pop in the same cycle never admits the push.
   assign fifo_push = wr_acc && (reg_sel == REG_TXDATA) && !fifo_full;
   assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
   assign busy      = (state != ST_IDLE);
   assign bit_end   = (cnt == bit_time - 16'd1);

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (bus.data_i[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         divisor  <= 16'(DEFAULT_DIV);
         overflow <= 1'b0;
      end else begin
         if (wr_acc && (reg_sel == REG_DIVISOR)) divisor <= bus.data_i[15:0];
         if (wr_acc && (reg_sel == REG_TXDATA) && fifo_full) overflow <= 1'b1;
         else if (wr_acc && (reg_sel == REG_STATUS)) overflow <= 1'b0;
      end
   end

   // Bit timing is frozen at frame start so DIVISOR writes only affect later frames.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         bit_time <= 16'd1;
         bit_idx  <= '0;
         tx_q     <= 1'b1;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state    <= ST_START;
                  bit_time <= eff_div(divisor);
                  cnt      <= '0;
                  tx_q     <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state   <= ST_DATA;
                  cnt     <= '0;
                  bit_idx <= '0;
                  tx_q    <= shreg[0];
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                     tx_q  <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx_q    <= shreg[bit_idx + 3'd1];
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               tx_q  <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_pop) shreg <= fifo_dout;
   end

   always_comb begin
      rdata = '0;
      if (rd_acc) begin
         unique case (reg_sel)
            REG_STATUS: begin
               rdata[STAT_BUSY]  = busy;
               rdata[STAT_FULL]  = fifo_full;
               rdata[STAT_EMPTY] = fifo_empty;
               rdata[STAT_OVF]   = overflow;
            end
            REG_DIVISOR:          rdata[15:0] = divisor;
            REG_TXDATA, REG_RSVD: rdata = '0;
            default:              rdata = '0;
         endcase
      end
   end

   assign bus.data_o = rdata;
   assign tx         = tx_q;
   assign irq        = fifo_empty && !busy;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: a line monitor decodes frames and compares them
// against a scoreboard of bytes queued by the register writes.
module tb_uart_tx_mmio;

   typedef struct {
      logic [7:0] data;
      int         bt;
      bit         chk;
   } frame_t;

   logic clk;
   logic rst;
   logic tx;
   logic irq;

   uart_tx_mmio_if bus_if ();

   uart_tx_mmio #(
      .FIFO_DEPTH  (4),
      .DEFAULT_DIV (434)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if),
      .tx  (tx),
      .irq (irq)
   );

   int     n_chk  = 0;
   int     n_fail = 0;
   int     cyc    = 0;
   int     model_div = 434;
   bit     mon_busy  = 0;
   frame_t sb[$];
   int     starts[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Line monitor: samples on the falling clock edge at the first cycle of each bit.
   initial begin : monitor
      logic       prev;
      logic [7:0] got;
      logic       stop_bit;
      frame_t     e;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (prev === 1'b1 && tx === 1'b0 && rst === 1'b0) begin
            mon_busy = 1;
            starts.push_back(cyc);
            if (sb.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_frame: frame start at cycle %0d, expected none", cyc);
               e.data = 8'h00; e.bt = 1; e.chk = 0;
            end else begin
               e = sb.pop_front();
            end
            got = '0;
            stop_bit = 1'b0;
            for (int k = 1; k <= 9; k++) begin
               repeat (e.bt) @(negedge clk);
               if (k <= 8) got[k-1] = tx;
               else stop_bit = tx;
            end
            if (e.chk) begin
               n_chk++;
               if (got !== e.data) begin
                  n_fail++;
                  $display("FAIL frame_data: got %02h expected %02h", got, e.data);
               end
               n_chk++;
               if (stop_bit !== 1'b1) begin
                  n_fail++;
                  $display("FAIL stop_bit: got %b expected 1 (byte %02h)", stop_bit, e.data);
               end
            end
            prev = tx;
            mon_busy = 0;
         end else begin
            prev = tx;
         end
      end
   end

   task automatic wr(input logic [1:0] off, input logic [31:0] d);
      bus_if.ce     = 1'b1;
      bus_if.we     = 1'b1;
      bus_if.addr   = {28'd0, off, 2'b00};
      bus_if.data_i = d;
      @(posedge clk);
      #1;
      bus_if.ce = 1'b0;
      bus_if.we = 1'b0;
      if (off == 2'd2) model_div = int'(d[15:0]);
   endtask

   task automatic rd(input logic [1:0] off, output logic [31:0] d);
      bus_if.ce   = 1'b1;
      bus_if.we   = 1'b0;
      bus_if.addr = {28'd0, off, 2'b00};
      #1;
      d = bus_if.data_o;
      bus_if.ce = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit chk);
      frame_t e;
      e.data = b;
      e.bt   = (model_div == 0) ? 1 : model_div;
      e.chk  = chk;
      sb.push_back(e);
      wr(2'd0, {24'd0, b});
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (!(sb.size() == 0 && !mon_busy && irq === 1'b1) && n < limit) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (n >= limit) begin
         n_fail++;
         $display("FAIL wait_idle: still busy after %0d cycles, %0d frames pending", n, sb.size());
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      n_chk++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
      n_chk++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL reset_irq: got %b expected 1", irq); end
      rd(2'd1, d);
      n_chk++;
      if (d !== 32'h4) begin n_fail++; $display("FAIL reset_status: got %0h expected 4", d); end
      rd(2'd2, d);
      n_chk++;
      if (d !== 32'd434) begin n_fail++; $display("FAIL reset_divisor: got %0d expected 434", d); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_div = 434;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic_frame();
      int n_busy;
      int n;
      logic first_irq;
      wr(2'd2, 32'd4);
      starts.delete();
      send_byte(8'hA5, 1);
      bus_if.ce = 1'b1; bus_if.we = 1'b0; bus_if.addr = 32'h4;
      n_busy = 0; n = 0;
      @(negedge clk);
      first_irq = irq;
      while (!(bus_if.data_o[0] === 1'b0 && irq === 1'b1) && n < 1000) begin
         if (bus_if.data_o[0] === 1'b1) n_busy++;
         @(negedge clk);
         n++;
      end
      bus_if.ce = 1'b0;
      n_chk++;
      if (first_irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_low: got %b expected 0", first_irq); end
      n_chk++;
      if (n_busy != 40) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 40", n_busy); end
      n_chk++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL basic_irq_after: got %b expected 1", irq); end
      wait_idle(200);
   endtask

   task automatic test_back_to_back_overflow();
      logic [31:0] d;
      wr(2'd2, 32'd2);
      starts.delete();
      // One byte leaves for the shift register at once, so four more fill the FIFO.
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1);
      wr(2'd0, 32'h06);
      rd(2'd1, d);
      n_chk++;
      if (d[3] !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b expected 1", d[3]); end
      n_chk++;
      if (d[1] !== 1'b1) begin n_fail++; $display("FAIL overflow_full: got %b expected 1", d[1]); end
      wr(2'd1, 32'h0);
      rd(2'd1, d);
      n_chk++;
      if (d[3] !== 1'b0) begin n_fail++; $display("FAIL overflow_clear: got %b expected 0", d[3]); end
      wait_idle(400);
      n_chk++;
      if (starts.size() != 5) begin n_fail++; $display("FAIL b2b_frames: got %0d expected 5", starts.size()); end
      for (int i = 1; i < starts.size(); i++) begin
         n_chk++;
         if (starts[i] - starts[i-1] != 21) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d expected 21 (frame %0d)", starts[i] - starts[i-1], i);
         end
      end
   endtask

   task automatic test_div_zero();
      int n_busy;
      int n;
      wr(2'd2, 32'd0);
      send_byte(8'h96, 1);
      bus_if.ce = 1'b1; bus_if.we = 1'b0; bus_if.addr = 32'h4;
      n_busy = 0; n = 0;
      @(negedge clk);
      while (!(bus_if.data_o[0] === 1'b0 && irq === 1'b1) && n < 200) begin
         if (bus_if.data_o[0] === 1'b1) n_busy++;
         @(negedge clk);
         n++;
      end
      bus_if.ce = 1'b0;
      n_chk++;
      if (n_busy != 10) begin n_fail++; $display("FAIL div0_frame_len: got %0d expected 10", n_busy); end
      wait_idle(100);
   endtask

   task automatic test_div_change();
      logic [31:0] d;
      wr(2'd2, 32'd3);
      starts.delete();
      send_byte(8'h3C, 1);
      repeat (6) @(posedge clk);
      #1;
      wr(2'd2, 32'd8);
      rd(2'd2, d);
      n_chk++;
      if (d !== 32'd8) begin n_fail++; $display("FAIL divchg_readback: got %0d expected 8", d); end
      send_byte(8'hC3, 1);
      wait_idle(400);
      n_chk++;
      if (starts.size() != 2) begin
         n_fail++;
         $display("FAIL divchg_frames: got %0d expected 2", starts.size());
      end else begin
         n_chk++;
         if (starts[1] - starts[0] != 31) begin
            n_fail++;
            $display("FAIL divchg_first_len: got %0d expected 31", starts[1] - starts[0]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] d;
      wr(2'd2, 32'd4);
      starts.delete();
      send_byte(8'h00, 0);
      wr(2'd0, 32'h55);
      repeat (10) @(posedge clk);
      #1;
      n_chk++;
      if (tx !== 1'b0) begin n_fail++; $display("FAIL abort_pre_tx: got %b expected 0", tx); end
      rst = 1'b1;
      #1;
      n_chk++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL abort_tx: got %b expected 1", tx); end
      n_chk++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL abort_irq: got %b expected 1", irq); end
      rd(2'd1, d);
      n_chk++;
      if (d !== 32'h4) begin n_fail++; $display("FAIL abort_status: got %0h expected 4", d); end
      rd(2'd2, d);
      n_chk++;
      if (d !== 32'd434) begin n_fail++; $display("FAIL abort_divisor: got %0d expected 434", d); end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_div = 434;
      wait_idle(200);
      repeat (20) @(posedge clk);
      #1;
      n_chk++;
      if (starts.size() != 1) begin n_fail++; $display("FAIL abort_discard: got %0d frames expected 1", starts.size()); end
   endtask

   task automatic test_reads();
      logic [31:0] d;
      int n;
      bus_if.ce = 1'b0; bus_if.we = 1'b0; bus_if.addr = 32'h4;
      #1;
      n_chk++;
      if (bus_if.data_o !== 32'h0) begin n_fail++; $display("FAIL read_ce0: got %0h expected 0", bus_if.data_o); end
      bus_if.ce = 1'b1; bus_if.we = 1'b1;
      #1;
      n_chk++;
      if (bus_if.data_o !== 32'h0) begin n_fail++; $display("FAIL read_we1: got %0h expected 0", bus_if.data_o); end
      bus_if.ce = 1'b0; bus_if.we = 1'b0;
      rd(2'd3, d);
      n_chk++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL read_rsvd: got %0h expected 0", d); end
      rd(2'd0, d);
      n_chk++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL read_txdata: got %0h expected 0", d); end
      wr(2'd2, 32'd50);
      wr(2'd3, 32'hFFFF);
      rd(2'd2, d);
      n_chk++;
      if (d !== 32'd50) begin n_fail++; $display("FAIL rsvd_write_ignored: got %0d expected 50", d); end
      for (int i = 0; i < 5; i++) send_byte(8'hF0 + 8'(i), 1);
      rd(2'd1, d);
      n_chk++;
      if (d !== 32'h3) begin n_fail++; $display("FAIL status_full_busy: got %0h expected 3", d); end
      bus_if.ce = 1'b1; bus_if.we = 1'b0; bus_if.addr = 32'h4;
      n = 0;
      @(negedge clk);
      while (bus_if.data_o[0] !== 1'b0 && n < 700) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (bus_if.data_o !== 32'h2) begin n_fail++; $display("FAIL status_full_idle: got %0h expected 2", bus_if.data_o); end
      bus_if.ce = 1'b0;
      wait_idle(3000);
   endtask

   initial begin
      rst = 1'b1;
      bus_if.ce = 1'b0;
      bus_if.we = 1'b0;
      bus_if.addr = '0;
      bus_if.data_i = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_basic_frame();
      test_back_to_back_overflow();
      test_div_zero();
      test_div_change();
      test_reset_mid_frame();
      test_reads();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
